// File: rtl/turn_sequencer.sv
// turn_sequencer: owns the 3x3 board; a commit is visible 1 cycle after the submit edge, turn/game_over 1 cycle later.
// No backpressure: off-turn submits are dropped. Define WIN_DETECT_EN to enable line detection (else full board/timeout only).
module turn_sequencer #(
  parameter int AI_FIRST     = 0,
  parameter int TURN_TIMEOUT = 1000,
  parameter int TO_W         = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        new_game,
  input  logic        player_submit,
  input  logic [3:0]  player_loc,
  input  logic        ai_submit,
  input  logic [3:0]  ai_loc,
  output logic [17:0] board_state,
  output logic        turn,
  output logic [3:0]  move_count,
  output logic        illegal_move,
  output logic        game_over,
  output logic [1:0]  winner
);

  localparam logic            TURN_AI = 1'b1;
  localparam logic [1:0]      MARK_X  = 2'b01;
  localparam logic [1:0]      MARK_O  = 2'b10;
  localparam logic [TO_W-1:0] TO_LIM  = TO_W'(TURN_TIMEOUT);
  localparam bit              TO_EN   = (TURN_TIMEOUT != 0);

  typedef enum logic [1:0] {S_WAIT, S_CHECK, S_DONE} state_t;

  state_t          state, state_n;
  logic [17:0]     board_n;
  logic            turn_n;
  logic [3:0]      count_n;
  logic            illegal_n;
  logic [1:0]      winner_n;
  logic [TO_W-1:0] timer, timer_n;
  logic            player_q, ai_q;
  logic            evt;
  logic [3:0]      loc;
  logic [1:0]      mark;
  logic            cell_blank;
  logic            line_done;

  // Only the side holding the turn can raise an event; the other strobe is ignored.
  assign evt       = (turn == TURN_AI) ? (ai_submit & ~ai_q) : (player_submit & ~player_q);
  assign loc       = (turn == TURN_AI) ? ai_loc : player_loc;
  assign mark      = (turn == TURN_AI) ? MARK_O : MARK_X;
  assign game_over = (state == S_DONE);

`ifdef WIN_DETECT_EN
  logic [8:0] own;

  always_comb begin
    own = '0;
    for (int i = 0; i < 9; i++) own[i] = (board_state[2*i +: 2] == mark);
  end

  assign line_done = (own[0] & own[1] & own[2]) | (own[3] & own[4] & own[5]) |
                     (own[6] & own[7] & own[8]) | (own[0] & own[3] & own[6]) |
                     (own[1] & own[4] & own[7]) | (own[2] & own[5] & own[8]) |
                     (own[0] & own[4] & own[8]) | (own[2] & own[4] & own[6]);
`else
  assign line_done = 1'b0;
`endif

  always_comb begin
    cell_blank = 1'b0;
    for (int i = 0; i < 9; i++)
      if (loc == 4'(i) && board_state[2*i +: 2] == 2'b00) cell_blank = 1'b1;
  end

  always_comb begin
    state_n   = state;
    board_n   = board_state;
    turn_n    = turn;
    count_n   = move_count;
    illegal_n = 1'b0;
    winner_n  = winner;
    timer_n   = timer;
    case (state)
      S_WAIT: begin
        if (TO_EN && timer != TO_LIM) timer_n = timer + TO_W'(1);
        if (evt && cell_blank) begin
          for (int i = 0; i < 9; i++)
            if (loc == 4'(i)) board_n[2*i +: 2] = mark;
          count_n = move_count + 4'd1;
          state_n = S_CHECK;
        end else begin
          // A rejected submit leaves the timer running, so it cannot stall a forfeit.
          illegal_n = evt;
          if (TO_EN && timer_n == TO_LIM) begin
            state_n  = S_DONE;
            winner_n = (turn == TURN_AI) ? MARK_X : MARK_O;
          end
        end
      end
      S_CHECK: begin
        if (line_done) begin
          state_n  = S_DONE;
          winner_n = mark;
        end else if (move_count == 4'd9) begin
          state_n  = S_DONE;
          winner_n = 2'b00;
        end else begin
          turn_n  = ~turn;
          timer_n = '0;
          state_n = S_WAIT;
        end
      end
      S_DONE:  ;
      default: state_n = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n || new_game) begin
      state        <= S_WAIT;
      board_state  <= '0;
      turn         <= 1'(AI_FIRST);
      move_count   <= '0;
      illegal_move <= 1'b0;
      winner       <= 2'b00;
      timer        <= '0;
      player_q     <= 1'b0;
      ai_q         <= 1'b0;
    end else begin
      state        <= state_n;
      board_state  <= board_n;
      turn         <= turn_n;
      move_count   <= count_n;
      illegal_move <= illegal_n;
      winner       <= winner_n;
      timer        <= timer_n;
      player_q     <= player_submit;
      ai_q         <= ai_submit;
    end
  end

endmodule
